// File: rtl/mmio_ep_in_if.sv
// Stream and status bundle between the MMIO controller, the Bulk-IN endpoint
// and the USB encoder. The slave modport is the endpoint's view.
interface mmio_ep_in_if;
  // read-data stream from the MMIO controller
  logic       dat_tvalid_i;
  logic       dat_tready_o;
  logic       dat_tlast_i;
  logic [7:0] dat_tdata_i;
  // status handshake
  logic        sts_vld_i;
  logic        sts_rdy_o;
  logic [3:0]  sts_tag_i;
  logic [3:0]  sts_err_i;
  logic [15:0] sts_len_i;
  // packet stream to the USB encoder
  logic       usb_tvalid_o;
  logic       usb_tready_i;
  logic       usb_tkeep_o;
  logic       usb_tlast_o;
  logic [7:0] usb_tdata_o;

  modport slave (
    input  dat_tvalid_i, dat_tlast_i, dat_tdata_i,
    input  sts_vld_i, sts_tag_i, sts_err_i, sts_len_i,
    input  usb_tready_i,
    output dat_tready_o, sts_rdy_o,
    output usb_tvalid_o, usb_tkeep_o, usb_tlast_o, usb_tdata_o
  );

  modport master (
    output dat_tvalid_i, dat_tlast_i, dat_tdata_i,
    output sts_vld_i, sts_tag_i, sts_err_i, sts_len_i,
    output usb_tready_i,
    input  dat_tready_o, sts_rdy_o,
    input  usb_tvalid_o, usb_tkeep_o, usb_tlast_o, usb_tdata_o
  );
endinterface

// File: rtl/mmio_ep_in.sv
// USB Bulk-IN endpoint: packs MMIO read data (or a 4-byte status frame) into a
// one-packet retransmit buffer and streams it out when the host selects the EP.
module mmio_ep_in #(
  parameter int unsigned BUF_SIZE = 64,
  parameter int unsigned BUF_BITS = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_conf_i,
  input  logic       clr_conf_i,
  input  logic [9:0] max_size_i,
  input  logic       selected_i,
  input  logic       timeout_i,
  input  logic       ack_recv_i,
  output logic       ep_ready_o,
  output logic       stalled_o,
  output logic       parity_o,
  output logic       mmio_sent_o,
  mmio_ep_in_if.slave bus
);

  localparam int unsigned CW = BUF_BITS + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] FULL  = 3'd2;
  localparam logic [2:0] SEND  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] STALL = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       max_q, max_d;
  logic [BUF_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic                zlp_q, zlp_d;
  logic                is_sts_q, is_sts_d;
  logic                parity_q, parity_d;
  logic                sent_q, sent_d;

  logic [7:0] mem [BUF_SIZE];

  logic fill_acc;
  logic sts_acc;
  logic beat;

  // Handshake outputs decoded from the current state
  always_comb begin
    bus.dat_tready_o = (state_q == FILL) && !zlp_q;
    bus.sts_rdy_o    = (state_q == FILL) && !zlp_q && (cnt_q == '0) && !bus.dat_tvalid_i;
    bus.usb_tvalid_o = (state_q == SEND);
    // an empty buffer in SEND is a ZLP: keep low, tlast high
    bus.usb_tkeep_o  = (state_q == SEND) && (cnt_q != '0);
    bus.usb_tlast_o  = (state_q == SEND) &&
                       ((cnt_q == '0) || ({1'b0, rd_ptr_q} == cnt_q - CW'(1)));
    bus.usb_tdata_o  = (state_q == SEND) ? mem[rd_ptr_q] : 8'h00;
    ep_ready_o       = (state_q == FULL);
    stalled_o        = (state_q == STALL);
    parity_o         = parity_q;
    mmio_sent_o      = sent_q;
    fill_acc         = bus.dat_tready_o && bus.dat_tvalid_i;
    sts_acc          = bus.sts_rdy_o && bus.sts_vld_i;
    beat             = bus.usb_tvalid_o && bus.usb_tready_i;
  end

  // Next-state logic for the endpoint FSM and its bookkeeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    rd_ptr_d = rd_ptr_q;
    zlp_d    = zlp_q;
    is_sts_d = is_sts_q;
    parity_d = parity_q;
    sent_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (set_conf_i) begin
          if ((max_size_i != 10'd0) && (max_size_i <= 10'(BUF_SIZE))) begin
            state_d  = FILL;
            max_d    = max_size_i[CW-1:0];
            parity_d = 1'b0;
          end else begin
            state_d = STALL;
          end
        end
      end
      FILL: begin
        if (zlp_q) begin
          // previous packet ended exactly on max_size: follow with an empty one
          state_d = FULL;
        end else if (fill_acc) begin
          cnt_d = cnt_q + CW'(1);
          if ((cnt_q + CW'(1) == max_q) || bus.dat_tlast_i) begin
            state_d = FULL;
          end
          if ((cnt_q + CW'(1) == max_q) && bus.dat_tlast_i) begin
            zlp_d = 1'b1;
          end
        end else if (sts_acc) begin
          cnt_d    = CW'(4);
          is_sts_d = 1'b1;
          state_d  = FULL;
        end
      end
      FULL: begin
        if (selected_i) begin
          state_d  = SEND;
          rd_ptr_d = '0;
        end
      end
      SEND: begin
        // host dropped the token: rewind and resend the whole packet later
        if (!selected_i) begin
          state_d = FULL;
        end else if (beat) begin
          if (bus.usb_tlast_o) begin
            state_d = WAIT;
          end else begin
            rd_ptr_d = rd_ptr_q + BUF_BITS'(1);
          end
        end
      end
      WAIT: begin
        if (ack_recv_i) begin
          parity_d = ~parity_q;
          cnt_d    = '0;
          // only the ZLP itself consumes the pending-ZLP flag
          if (cnt_q == '0) begin
            zlp_d = 1'b0;
          end
          sent_d   = is_sts_q;
          is_sts_d = 1'b0;
          state_d  = FILL;
        end else if (timeout_i) begin
          state_d = FULL;
        end
      end
      STALL: begin
        state_d = STALL;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clr_conf_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      max_d    = '0;
      rd_ptr_d = '0;
      zlp_d    = 1'b0;
      is_sts_d = 1'b0;
      parity_d = 1'b0;
      sent_d   = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      max_q    <= '0;
      rd_ptr_q <= '0;
      zlp_q    <= 1'b0;
      is_sts_q <= 1'b0;
      parity_q <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      rd_ptr_q <= rd_ptr_d;
      zlp_q    <= zlp_d;
      is_sts_q <= is_sts_d;
      parity_q <= parity_d;
      sent_q   <= sent_d;
    end
  end

  // Packet buffer writes: data bytes one at a time, status frame in one go
  always_ff @(posedge clock) begin
    if (fill_acc) begin
      mem[cnt_q[BUF_BITS-1:0]] <= bus.dat_tdata_i;
    end else if (sts_acc) begin
      mem[BUF_BITS'(0)] <= 8'h53;
      mem[BUF_BITS'(1)] <= {bus.sts_tag_i, bus.sts_err_i};
      mem[BUF_BITS'(2)] <= bus.sts_len_i[7:0];
      mem[BUF_BITS'(3)] <= bus.sts_len_i[15:8];
    end
  end

endmodule

// File: tb/tb_mmio_ep_in.sv
// Directed bench for the Bulk-IN endpoint: configuration, short and multi-packet
// transfers with ZLP, retransmit on timeout, status frame and abort.
module tb_mmio_ep_in;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       set_conf_i = 1'b0;
  logic       clr_conf_i = 1'b0;
  logic [9:0] max_size_i = '0;
  logic       selected_i = 1'b0;
  logic       timeout_i = 1'b0;
  logic       ack_recv_i = 1'b0;
  logic       ep_ready_o;
  logic       stalled_o;
  logic       parity_o;
  logic       mmio_sent_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q [$];

  mmio_ep_in_if bus ();

  mmio_ep_in #(
    .BUF_SIZE (64),
    .BUF_BITS (6)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .set_conf_i  (set_conf_i),
    .clr_conf_i  (clr_conf_i),
    .max_size_i  (max_size_i),
    .selected_i  (selected_i),
    .timeout_i   (timeout_i),
    .ack_recv_i  (ack_recv_i),
    .ep_ready_o  (ep_ready_o),
    .stalled_o   (stalled_o),
    .parity_o    (parity_o),
    .mmio_sent_o (mmio_sent_o),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ep_ready"}, ep_ready_o, 0);
    chk({tag, " stalled"}, stalled_o, 0);
    chk({tag, " parity"}, parity_o, 0);
    chk({tag, " mmio_sent"}, mmio_sent_o, 0);
    chk({tag, " dat_tready"}, bus.dat_tready_o, 0);
    chk({tag, " usb_tvalid"}, bus.usb_tvalid_o, 0);
    chk({tag, " usb_tkeep"}, bus.usb_tkeep_o, 0);
    chk({tag, " usb_tlast"}, bus.usb_tlast_o, 0);
    chk({tag, " usb_tdata"}, bus.usb_tdata_o, 0);
  endtask

  task automatic configure(input logic [9:0] max);
    set_conf_i = 1'b1;
    max_size_i = max;
    step();
    set_conf_i = 1'b0;
  endtask

  task automatic clear();
    clr_conf_i = 1'b1;
    step();
    clr_conf_i = 1'b0;
  endtask

  // Push n bytes base, base+1, ... into the endpoint; expected queue mirrors them
  task automatic fill(input logic [7:0] base, input int n, input bit last);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      bus.dat_tvalid_i = 1'b1;
      bus.dat_tdata_i  = base + 8'(i);
      bus.dat_tlast_i  = last && (i == n - 1);
      chk("fill dat_tready", bus.dat_tready_o, 1);
      exp_q.push_back(base + 8'(i));
      step();
    end
    bus.dat_tvalid_i = 1'b0;
    bus.dat_tlast_i  = 1'b0;
    chk("ep_ready after fill", ep_ready_o, 1);
  endtask

  // Select the endpoint and check every beat against exp_q (empty = ZLP)
  task automatic recv(input string tag, input bit exp_par, input int stall_at);
    int n;
    n = exp_q.size();
    selected_i = 1'b1;
    bus.usb_tready_i = 1'b1;
    step();
    chk({tag, " first beat tvalid"}, bus.usb_tvalid_o, 1);
    if (n == 0) begin
      chk({tag, " zlp tkeep"}, bus.usb_tkeep_o, 0);
      chk({tag, " zlp tlast"}, bus.usb_tlast_o, 1);
      chk({tag, " zlp parity"}, parity_o, exp_par);
      step();
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i == stall_at) begin
          bus.usb_tready_i = 1'b0;
          step();
          chk({tag, " held data"}, bus.usb_tdata_o, exp_q[i]);
          bus.usb_tready_i = 1'b1;
        end
        chk({tag, " tdata"}, bus.usb_tdata_o, exp_q[i]);
        chk({tag, " tkeep"}, bus.usb_tkeep_o, 1);
        chk({tag, " tlast"}, bus.usb_tlast_o, (i == n - 1) ? 1 : 0);
        chk({tag, " parity"}, parity_o, exp_par);
        step();
      end
    end
    selected_i = 1'b0;
    chk({tag, " tvalid after tlast"}, bus.usb_tvalid_o, 0);
    chk({tag, " ep_ready in wait"}, ep_ready_o, 0);
  endtask

  task automatic ack(input bit exp_par, input bit exp_sent);
    ack_recv_i = 1'b1;
    step();
    ack_recv_i = 1'b0;
    chk("ack parity", parity_o, exp_par);
    chk("ack mmio_sent", mmio_sent_o, exp_sent);
  endtask

  initial begin
    bus.dat_tvalid_i = 1'b0;
    bus.dat_tlast_i  = 1'b0;
    bus.dat_tdata_i  = 8'h00;
    bus.sts_vld_i    = 1'b0;
    bus.sts_tag_i    = 4'h0;
    bus.sts_err_i    = 4'h0;
    bus.sts_len_i    = 16'h0;
    bus.usb_tready_i = 1'b1;

    // Reset: all outputs low
    step();
    step();
    chk_all_zero("reset");
    chk("reset sts_rdy", bus.sts_rdy_o, 0);
    reset = 1'b1;
    step();

    // Oversized max packet stalls; clr_conf recovers
    configure(10'd80);
    chk("stall on max 80", stalled_o, 1);
    chk("stall dat_tready", bus.dat_tready_o, 0);
    clear();
    chk("stall cleared", stalled_o, 0);

    // Legal configuration
    configure(10'd64);
    chk("conf ep_ready", ep_ready_o, 0);
    chk("conf dat_tready", bus.dat_tready_o, 1);
    chk("conf stalled", stalled_o, 0);

    // Short fetch with one backpressure cycle
    fill(8'h10, 7, 1'b1);
    recv("short", 1'b0, 3);
    ack(1'b1, 1'b0);

    // Multi-packet with ZLP and one retransmit, fresh parity
    clear();
    configure(10'd64);
    chk("reconf parity", parity_o, 0);
    fill(8'h00, 64, 1'b0);
    recv("pkt0", 1'b0, -1);
    timeout_i = 1'b1;
    step();
    timeout_i = 1'b0;
    chk("timeout ep_ready", ep_ready_o, 1);
    chk("timeout parity", parity_o, 0);
    recv("pkt0 resend", 1'b0, -1);
    ack(1'b1, 1'b0);
    fill(8'h40, 64, 1'b1);
    recv("pkt1", 1'b1, -1);
    ack(1'b0, 1'b0);
    chk("zlp pending dat_tready", bus.dat_tready_o, 0);
    step();
    chk("zlp ep_ready", ep_ready_o, 1);
    exp_q.delete();
    recv("zlp", 1'b0, -1);
    ack(1'b1, 1'b0);
    chk("after zlp dat_tready", bus.dat_tready_o, 1);

    // Status frame
    bus.sts_vld_i = 1'b1;
    bus.sts_tag_i = 4'hA;
    bus.sts_err_i = 4'h0;
    bus.sts_len_i = 16'h0007;
    #1;
    chk("sts_rdy", bus.sts_rdy_o, 1);
    step();
    bus.sts_vld_i = 1'b0;
    chk("sts_rdy one cycle", bus.sts_rdy_o, 0);
    chk("sts ep_ready", ep_ready_o, 1);
    exp_q.delete();
    exp_q.push_back(8'h53);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h00);
    recv("status", 1'b1, -1);
    ack(1'b0, 1'b1);
    step();
    chk("mmio_sent single pulse", mmio_sent_o, 0);

    // Simultaneous ack and timeout: ack wins
    fill(8'h99, 1, 1'b1);
    recv("ack+to", 1'b0, -1);
    ack_recv_i = 1'b1;
    timeout_i  = 1'b1;
    step();
    ack_recv_i = 1'b0;
    timeout_i  = 1'b0;
    chk("ack wins parity", parity_o, 1);
    chk("ack wins ep_ready", ep_ready_o, 0);
    chk("ack wins dat_tready", bus.dat_tready_o, 1);

    // Abort mid-SEND, then normal operation after reconfiguration
    fill(8'h30, 5, 1'b1);
    selected_i = 1'b1;
    step();
    step();
    chk("abort mid-send tvalid", bus.usb_tvalid_o, 1);
    clr_conf_i = 1'b1;
    step();
    clr_conf_i = 1'b0;
    selected_i = 1'b0;
    chk_all_zero("abort");
    configure(10'd64);
    chk("post-abort dat_tready", bus.dat_tready_o, 1);
    fill(8'h21, 2, 1'b1);
    recv("post-abort", 1'b0, -1);
    ack(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
